// File: rtl/booth_pkg.sv
// booth_pkg: shared FSM states, Booth digit codes and sizing helper
`timescale 1ns/1ps
package booth_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    // digit code layout is {neg, two, one}
    typedef logic [2:0] digit_t;
    localparam digit_t ZERO = 3'b000;
    localparam digit_t P1   = 3'b001;
    localparam digit_t P2   = 3'b010;
    localparam digit_t M1   = 3'b101;
    localparam digit_t M2   = 3'b110;
    function automatic int booth_ndig(input int w);
        return w / 2 + 1;
    endfunction
endpackage

// File: rtl/booth_r4_digit.sv
// booth_r4_digit: decodes a 3-bit multiplier window into a radix-4 Booth digit
`timescale 1ns/1ps
module booth_r4_digit
    import booth_pkg::*;
(
    input  logic [2:0] win,
    output logic       neg,
    output logic       one,
    output logic       two
);
    digit_t code;
    // window {b[2i+1], b[2i], b[2i-1]} -> digit in {-2..+2}; 111 is zero, not negative zero
    always_comb begin
        case (win)
            3'b001, 3'b010: code = P1;
            3'b011:         code = P2;
            3'b100:         code = M2;
            3'b101, 3'b110: code = M1;
            default:        code = ZERO;
        endcase
    end
    assign {neg, two, one} = code;
endmodule

// File: rtl/booth_r4_mac_acc.sv
// booth_r4_mac_acc: iterative radix-4 Booth multiply-accumulate, one digit per cycle
`timescale 1ns/1ps
module booth_r4_mac_acc
    import booth_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int GUARD = 8,
    localparam int ACC_W = 2 * WIDTH + GUARD,
    localparam int NDIG  = booth_ndig(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             acc_clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf
);
    localparam int MW = WIDTH + 3;
    localparam int CW = $clog2(NDIG + 1);
    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [ACC_W-1:0] mcand, prod, sel, pp_nx, base;
    logic [MW-1:0]    mplr;
    logic             sgn_q, clr_q, neg, one, two, add_ovf;
    logic [ACC_W:0]   sum;
    booth_r4_digit u_dig (
        .win (mplr[2:0]),
        .neg (neg),
        .one (one),
        .two (two)
    );
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // next-state: NDIG digit cycles in RUN, then a single FIN cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = (cnt == CW'(NDIG - 1)) ? FIN : RUN;
            default: state_nx = IDLE;
        endcase
    end
    // outputs decoded from state
    always_comb begin
        busy = (state == RUN);
    end
    // partial product step and accumulation add with overflow detection
    always_comb begin
        sel     = two ? {mcand[ACC_W-2:0], 1'b0} : (one ? mcand : '0);
        pp_nx   = prod + (sel ^ {ACC_W{neg}}) + {{(ACC_W-1){1'b0}}, neg};
        base    = clr_q ? '0 : acc_out;
        sum     = {1'b0, base} + {1'b0, prod};
        add_ovf = sgn_q ? (base[ACC_W-1] == prod[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1])
                        : sum[ACC_W];
    end
    // datapath registers: capture in IDLE, iterate in RUN, retire in FIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            prod    <= '0;
            sgn_q   <= 1'b0;
            clr_q   <= 1'b0;
            acc_out <= '0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (state == FIN);
            if (state == IDLE && start) begin
                mcand <= {{(ACC_W-WIDTH){signed_mode & a[WIDTH-1]}}, a};
                mplr  <= {{2{signed_mode & b[WIDTH-1]}}, b, 1'b0};
                sgn_q <= signed_mode;
                clr_q <= acc_clr;
                cnt   <= '0;
                prod  <= '0;
            end else if (state == RUN) begin
                prod  <= pp_nx;
                mcand <= {mcand[ACC_W-3:0], 2'b00};
                mplr  <= {2'b00, mplr[MW-1:2]};
                cnt   <= cnt + CW'(1);
            end else if (state == FIN) begin
                acc_out <= sum[ACC_W-1:0];
                ovf     <= clr_q ? add_ovf : (ovf | add_ovf);
            end
        end
    end
endmodule

// File: tb/tb_booth_r4_mac_acc.sv
// tb_booth_r4_mac_acc: directed checks of the Booth MAC at GUARD=8 and GUARD=0
`timescale 1ns/1ps
module tb_booth_r4_mac_acc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        signed_mode = 1'b0, acc_clr = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy0, done0, ovf0, busy1, done1, ovf1;
    logic [71:0] acc0;
    logic [63:0] acc1;
    int          nvec = 0, nmis = 0;
    always #5 clk = ~clk;
    booth_r4_mac_acc #(.WIDTH(32), .GUARD(8)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .signed_mode(signed_mode), .acc_clr(acc_clr),
        .a(a), .b(b), .busy(busy0), .done(done0), .acc_out(acc0), .ovf(ovf0)
    );
    booth_r4_mac_acc #(.WIDTH(32), .GUARD(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .signed_mode(signed_mode), .acc_clr(acc_clr),
        .a(a), .b(b), .busy(busy1), .done(done1), .acc_out(acc1), .ovf(ovf1)
    );
    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    // one MAC on dut0 (u=0) or dut1 (u=1); checks latency, busy length and done width
    task automatic op(input bit u, input bit sg, input bit cl, input logic [31:0] aa, input logic [31:0] bb);
        int k, nb;
        bit got;
        @(negedge clk);
        signed_mode = sg; acc_clr = cl; a = aa; b = bb;
        start0 = !u; start1 = u;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        k = 0; nb = 0; got = 1'b0;
        while (!got && k < 40) begin
            if (u ? done1 : done0) got = 1'b1;
            else begin
                nb += int'(u ? busy1 : busy0);
                @(posedge clk); #1;
                k++;
            end
        end
        chk("done_seen", 72'(got), 72'd1);
        chk("latency", 72'(k), 72'd18);
        chk("busy_cycles", 72'(nb), 72'd17);
        @(posedge clk); #1;
        chk("done_width", 72'(u ? done1 : done0), 72'd0);
    endtask
    initial begin
        int k, nd, first;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 72'(busy0), 72'd0);
        chk("rst_done", 72'(done0), 72'd0);
        chk("rst_acc", acc0, 72'd0);
        chk("rst_ovf", 72'(ovf0), 72'd0);
        @(negedge clk); rst = 1'b0;
        op(0, 1, 1, 32'hFFFF_FFFD, 32'd7);
        chk("s_m3x7", acc0, 72'hFF_FFFF_FFFF_FFFF_FFEB);
        chk("s_m3x7_ovf", 72'(ovf0), 72'd0);
        op(0, 1, 0, 32'd5, 32'hFFFF_FFFC);
        chk("acc_m41", acc0, 72'hFF_FFFF_FFFF_FFFF_FFD7);
        op(0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("u_max_sq", acc0, 72'h00_FFFF_FFFE_0000_0001);
        op(0, 1, 1, 32'h8000_0000, 32'h8000_0000);
        chk("s_minneg_sq", acc0, 72'h00_4000_0000_0000_0000);
        op(0, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("s_m1xm1_acc", acc0, 72'h00_4000_0000_0000_0001);
        op(0, 0, 0, 32'h10, 32'd3);
        chk("u_16x3_acc", acc0, 72'h00_4000_0000_0000_0031);
        chk("no_ovf", 72'(ovf0), 72'd0);
        op(1, 1, 1, 32'h8000_0000, 32'h8000_0000);
        chk("g0_first", {8'h0, acc1}, 72'h00_4000_0000_0000_0000);
        chk("g0_first_ovf", 72'(ovf1), 72'd0);
        op(1, 1, 0, 32'h8000_0000, 32'h8000_0000);
        chk("g0_wrap", {8'h0, acc1}, 72'h00_8000_0000_0000_0000);
        chk("g0_wrap_ovf", 72'(ovf1), 72'd1);
        op(1, 1, 0, 32'd0, 32'd0);
        chk("g0_hold", {8'h0, acc1}, 72'h00_8000_0000_0000_0000);
        chk("g0_sticky", 72'(ovf1), 72'd1);
        op(1, 1, 1, 32'd2, 32'd3);
        chk("g0_clr", {8'h0, acc1}, 72'd6);
        chk("g0_clr_ovf", 72'(ovf1), 72'd0);
        op(1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        op(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("g0_u_carry", {8'h0, acc1}, 72'h00_FFFF_FFFC_0000_0002);
        chk("g0_u_ovf", 72'(ovf1), 72'd1);
        // second start while running must be dropped
        @(negedge clk);
        signed_mode = 1'b1; acc_clr = 1'b1; a = 32'd3; b = 32'd4; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        nd = 0; first = -1;
        for (k = 0; k < 40; k++) begin
            if (k == 5) begin a = 32'd100; b = 32'd100; acc_clr = 1'b0; start0 = 1'b1; end
            else start0 = 1'b0;
            if (done0) begin nd++; if (first < 0) first = k; end
            @(posedge clk); #1;
        end
        chk("ign_done_cnt", 72'(nd), 72'd1);
        chk("ign_latency", 72'(first), 72'd18);
        chk("ign_result", acc0, 72'd12);
        // asynchronous reset between edges in the middle of RUN
        @(negedge clk);
        signed_mode = 1'b1; acc_clr = 1'b0; a = 32'd9; b = 32'd9; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", 72'(busy0), 72'd0);
        chk("arst_acc", acc0, 72'd0);
        chk("arst_ovf", 72'(ovf0), 72'd0);
        chk("arst_ovf_g0", 72'(ovf1), 72'd0);
        @(negedge clk); rst = 1'b0;
        nd = 0;
        for (k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            nd += int'(done0);
        end
        chk("arst_no_done", 72'(nd), 72'd0);
        op(0, 1, 1, 32'd6, 32'd7);
        chk("arst_recover", acc0, 72'd42);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/booth_r4_mac_acc.md
Name: booth_r4_mac_acc

Overview:
Parametrised iterative radix-4 Booth multiply-accumulate unit. It computes acc <= acc + a*b, retiring one Booth digit per cycle. The multiplier operates directly on two's-complement operands in signed mode and on zero-extended operands in unsigned mode, with no sign-magnitude conversion. The accumulator is wide, with guard bits and a sticky overflow flag. It is the next-generation MAC in the floating-point arithmetic library and serves as the mantissa/integer dot-product engine for the FMA and dot-product datapaths.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4
GUARD, 8, extra accumulator bits above 2*WIDTH
ACC_W, 2*WIDTH+GUARD, accumulator width (derived, not overridable)
NDIG, WIDTH/2+1, Booth digits per multiply (derived)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a MAC operation; sampled only in IDLE
signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; captured at start
acc_clr  input  1  1 = discard old accumulator (acc = a*b); captured at start
a  input  WIDTH  multiplicand; captured at start
b  input  WIDTH  multiplier; captured at start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when acc_out holds the new result
acc_out  output  ACC_W  accumulator value (registered)
ovf  output  1  sticky accumulator overflow flag

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, acc_out=0, ovf=0, internal product/shift registers=0.
- FSM states: IDLE, RUN, FIN.
- IDLE, start=1: capture operands and mode bits.
  - Multiplicand is extended to ACC_W bits: sign-extended if signed_mode, else zero-extended.
  - Multiplier is extended to WIDTH+2 bits, then a 0 is appended below the LSB.
  - Digit counter is cleared, the partial product is cleared, state goes to RUN.
- IDLE, start=0: stay in IDLE.
- RUN:
  - Each cycle, decode the low 3 bits of the multiplier shift register into a digit in {-2,-1,0,+1,+2}.
  - Add digit*multiplicand to the partial product, modulo 2^ACC_W.
  - Shift the multiplicand left by 2 and the multiplier right by 2.
  - After NDIG cycles, go to FIN.
- FIN (one cycle):
  - acc_out <= (clr_q ? 0 : acc_out) + product, modulo 2^ACC_W.
  - done=1 for this cycle only, busy=0, next state IDLE.
- Latency: done is asserted NDIG+1 cycles after the clk edge that sampled start; for WIDTH=32 this is 18 cycles.
- Throughput: one operation per NDIG+2 cycles. start asserted in FIN or while busy is ignored and not queued.
- Overflow detection is evaluated at the FIN add:
  - Signed mode: operands have the same sign and the result sign differs.
  - Unsigned mode: carry out of bit ACC_W-1.
- ovf is set and held. It is cleared only by reset, or by a FIN whose captured acc_clr=1; in that case ovf takes the overflow of that add (always 0 for a single product).
- The product alone never overflows: NDIG digits fit in 2*WIDTH+2 <= ACC_W bits when GUARD >= 2. The required minimum is GUARD >= 0; with GUARD < 2, only the accumulation add may wrap.
- acc_out changes only in FIN or on reset. It is stable between done pulses and readable at any time.
- Changing a, b, signed_mode or acc_clr while busy has no effect.
- Reset mid-RUN aborts the operation: no done pulse, acc_out=0.
- Most-negative operands (0x8000_0000 × 0x8000_0000 in signed mode) must give +2^62 exactly.

Decomposition:
- Shared package booth_pkg holds:
  - FSM state enum {IDLE, RUN, FIN}
  - Booth digit encoding constants (ZERO, P1, P2, M1, M2)
  - function for NDIG
- One natural sub-module, booth_r4_digit: combinational 3-bit-window decoder. It outputs neg, one and two, which the datapath uses to select 0, m or 2m and conditionally complement (with +1 carry-in).
- Datapath adder and FSM stay in the top module.

Test Plan:
- WIDTH=32: signed, acc_clr=1, a=-3, b=7 -> done exactly 18 cycles after the start edge; acc_out=-21 sign-extended to 72 bits (0xFF..FFEB); ovf=0.
- Same bench, next op: signed, acc_clr=0, a=5, b=-4 -> acc_out=-41; busy high for 17 cycles, then done pulses 1 cycle.
- Unsigned, acc_clr=1, a=0xFFFFFFFF, b=0xFFFFFFFF -> acc_out=0xFFFFFFFE00000001. Then signed, acc_clr=1, a=0x80000000, b=0x80000000 -> acc_out=0x4000000000000000.
- GUARD=0 (ACC_W=64): signed, acc_clr=1, 0x80000000², then acc_clr=0, same operands -> acc_out=0x8000000000000000 and ovf=1. A third op with acc_clr=0, a=0, b=0 keeps ovf=1; a fourth with acc_clr=1 clears it.
- Start pulsed again 5 cycles into RUN with different operands -> ignored; result matches the first operands only, and exactly one done pulse.
- Async rst asserted mid-RUN, between clock edges -> busy=0, acc_out=0, ovf=0 immediately. No done pulse; the next start completes normally.
